seq_fsm_param: RTL and testbench

- Parametrised four-phase sequencer: IDLE, CYCLE, RAMP, HOLD.
- CYCLE emits a wrapping count with an optional selectable offset. RAMP emits a 0..limit ramp. HOLD waits for an acknowledge or a timeout.
- Adds runtime-configurable limits, a pause input, valid strobes, a done pulse and an optional HOLD timeout.
- Sits between the control/sequencing logic and the data-path consumers of o_data1/o_data2.

---
 rtl/seq_fsm_param.sv | 150 +++++++++++++++
 tb/tb_seq_fsm_param.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_fsm_param.sv
// Four-phase sequencer IDLE -> CYCLE -> RAMP -> HOLD with runtime limits,
// pause, valid strobes, a done pulse and an optional HOLD timeout.
module seq_fsm_param #(
    parameter int unsigned DW         = 8,
    parameter int unsigned CYC_DEF    = 9,
    parameter int unsigned RAMP_DEF   = 20,
    parameter int unsigned SEL_OFFSET = 10,
    parameter int unsigned HOLD_TO    = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_go,
    input  logic          i_next,
    input  logic          i_ack,
    input  logic          i_pause,
    input  logic          i_sel,
    input  logic          i_sel_valid,
    input  logic          i_cfg_valid,
    input  logic [DW-1:0] i_cfg_cyc_max,
    input  logic [DW-1:0] i_cfg_ramp_max,
    output logic [3:0]    o_state,
    output logic [DW-1:0] o_data1,
    output logic          o_data1_vld,
    output logic [DW-1:0] o_data2,
    output logic          o_data2_vld,
    output logic          o_done,
    output logic          o_busy
);

    localparam int unsigned HW        = (HOLD_TO > 0) ? $clog2(HOLD_TO + 1) : 1;
    localparam bit          HoldToEn  = (HOLD_TO > 0);
    localparam logic [HW-1:0] HoldLast = HW'((HOLD_TO > 0) ? HOLD_TO - 1 : 0);

    typedef enum logic [3:0] {
        StIdle  = 4'b0000,
        StCycle = 4'b0001,
        StRamp  = 4'b0010,
        StHold  = 4'b0100
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] cnt1_q, cnt1_d;
    logic [DW-1:0] cnt2_q, cnt2_d;
    logic [DW-1:0] cyc_max_q, cyc_max_d;
    logic [DW-1:0] ramp_max_q, ramp_max_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          sel_q, sel_d;
    logic          done_q, done_d;

    always_comb begin
        state_d    = state_q;
        cnt1_d     = cnt1_q;
        cnt2_d     = cnt2_q;
        cyc_max_d  = cyc_max_q;
        ramp_max_d = ramp_max_q;
        hold_cnt_d = hold_cnt_q;
        sel_d      = sel_q;
        done_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_sel_valid) begin
                    sel_d = i_sel;
                end
                if (i_cfg_valid) begin
                    cyc_max_d  = i_cfg_cyc_max;
                    ramp_max_d = i_cfg_ramp_max;
                end
                if (i_go) begin
                    state_d = StCycle;
                    cnt1_d  = '0;
                end
            end
            StCycle: begin
                if (!i_pause) begin
                    cnt1_d = (cnt1_q == cyc_max_q) ? '0 : cnt1_q + 1'b1;
                end
                // i_next is honoured regardless of pause
                if (i_next) begin
                    state_d = StRamp;
                    cnt2_d  = '0;
                end
            end
            StRamp: begin
                if (!i_pause) begin
                    if (cnt2_q == ramp_max_q) begin
                        state_d    = StHold;
                        hold_cnt_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        cnt2_d = cnt2_q + 1'b1;
                    end
                end
            end
            StHold: begin
                if (i_ack) begin
                    state_d = StIdle;
                end else if (HoldToEn) begin
                    if (hold_cnt_q == HoldLast) begin
                        state_d = StIdle;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt1_q     <= '0;
            cnt2_q     <= '0;
            cyc_max_q  <= DW'(CYC_DEF);
            ramp_max_q <= DW'(RAMP_DEF);
            hold_cnt_q <= '0;
            sel_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt1_q     <= cnt1_d;
            cnt2_q     <= cnt2_d;
            cyc_max_q  <= cyc_max_d;
            ramp_max_q <= ramp_max_d;
            hold_cnt_q <= hold_cnt_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        o_state     = state_q;
        o_busy      = (state_q != StIdle);
        o_data1_vld = (state_q == StCycle);
        o_data2_vld = (state_q == StRamp);
        o_done      = done_q && (state_q == StHold);
        o_data1     = '0;
        o_data2     = '0;
        if (state_q == StCycle) begin
            o_data1 = cnt1_q + (sel_q ? DW'(SEL_OFFSET) : DW'(0));
        end
        if (state_q == StRamp) begin
            o_data2 = cnt2_q;
        end
    end

endmodule

// File: tb/tb_seq_fsm_param.sv
// Randomised self-checking bench for seq_fsm_param; expectations come from
// per-pass arithmetic (wrap counts, ramp positions, hold lengths).
module tb_seq_fsm_param;

    localparam int CYC_DEF    = 9;
    localparam int RAMP_DEF   = 20;
    localparam int SEL_OFFSET = 10;

    logic       clk;
    logic       rst;
    logic       go, nxt, ack, pause, sel, sel_valid, cfg_valid;
    logic [7:0] cfg_cyc, cfg_ramp;

    logic [3:0] o_state, t_state;
    logic [7:0] o_data1, o_data2, t_data1, t_data2;
    logic       o_data1_vld, o_data2_vld, o_done, o_busy;
    logic       t_data1_vld, t_data2_vld, t_done, t_busy;

    logic [23:0] obs, obs_t;
    assign obs   = {o_state, o_data1, o_data1_vld, o_data2, o_data2_vld, o_done, o_busy};
    assign obs_t = {t_state, t_data1, t_data1_vld, t_data2, t_data2_vld, t_done, t_busy};

    int n_cmp = 0;
    int n_bad = 0;

    seq_fsm_param dut (
        .clk(clk), .rst(rst), .i_go(go), .i_next(nxt), .i_ack(ack), .i_pause(pause),
        .i_sel(sel), .i_sel_valid(sel_valid), .i_cfg_valid(cfg_valid),
        .i_cfg_cyc_max(cfg_cyc), .i_cfg_ramp_max(cfg_ramp),
        .o_state(o_state), .o_data1(o_data1), .o_data1_vld(o_data1_vld),
        .o_data2(o_data2), .o_data2_vld(o_data2_vld), .o_done(o_done), .o_busy(o_busy)
    );

    seq_fsm_param #(.HOLD_TO(4)) dut_to (
        .clk(clk), .rst(rst), .i_go(go), .i_next(nxt), .i_ack(ack), .i_pause(pause),
        .i_sel(sel), .i_sel_valid(sel_valid), .i_cfg_valid(cfg_valid),
        .i_cfg_cyc_max(cfg_cyc), .i_cfg_ramp_max(cfg_ramp),
        .o_state(t_state), .o_data1(t_data1), .o_data1_vld(t_data1_vld),
        .o_data2(t_data2), .o_data2_vld(t_data2_vld), .o_done(t_done), .o_busy(t_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observable output word for a given phase: st is the 4-bit phase code.
    function automatic logic [23:0] exp_obs(input int st, input int d1, input int d2,
                                            input bit dn);
        return {4'(st), 8'(d1), st == 1, 8'(d2), st == 2, dn, st != 0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        go = 0; nxt = 0; ack = 0; pause = 0; sel = 0; sel_valid = 0; cfg_valid = 0;
        cfg_cyc = 8'd0; cfg_ramp = 8'd0;
    endtask

    task automatic pulse_reset();
        rst = 0;
        @(posedge clk);
        #1;
        rst = 1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== 24'h0) begin
            n_bad++; $display("FAIL reset_obs got=%h exp=%h", obs, 24'h0);
        end
        n_cmp++;
        if (obs_t !== 24'h0) begin
            n_bad++; $display("FAIL reset_obs_to got=%h exp=%h", obs_t, 24'h0);
        end
        rst = 1;
        step();
        n_cmp++;
        if (obs !== 24'h0) begin
            n_bad++; $display("FAIL reset_idle got=%h exp=%h", obs, 24'h0);
        end
    endtask

    task automatic test_default_pass();
        logic [23:0] e;
        sel_valid = 1; sel = 1; go = 1;
        step();
        clear_inputs();
        for (int k = 0; k < 12; k++) begin
            e = exp_obs(1, (k % (CYC_DEF + 1)) + SEL_OFFSET, 0, 0);
            n_cmp++;
            if (obs !== e) begin
                n_bad++; $display("FAIL dflt_cycle k=%0d got=%h exp=%h", k, obs, e);
            end
            if (k == 11) nxt = 1;
            step();
            nxt = 0;
        end
        for (int j = 0; j <= RAMP_DEF; j++) begin
            e = exp_obs(2, 0, j, 0);
            n_cmp++;
            if (obs !== e) begin
                n_bad++; $display("FAIL dflt_ramp j=%0d got=%h exp=%h", j, obs, e);
            end
            step();
        end
        e = exp_obs(4, 0, 0, 1);
        n_cmp++;
        if (obs !== e) begin
            n_bad++; $display("FAIL dflt_done got=%h exp=%h", obs, e);
        end
        step();
        e = exp_obs(4, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++; $display("FAIL dflt_hold got=%h exp=%h", obs, e);
        end
        ack = 1;
        step();
        ack = 0;
        n_cmp++;
        if (obs !== 24'h0) begin
            n_bad++; $display("FAIL dflt_idle got=%h exp=%h", obs, 24'h0);
        end
    endtask

    task automatic test_random_passes();
        logic [23:0] e;
        int cm, rm, ncyc, active, r, hw;
        bit s, pz, fin;
        for (int p = 0; p < 8; p++) begin
            if (p == 0) begin
                cm = 3; rm = 5; s = 0; ncyc = 6;
            end else begin
                cm = $urandom_range(0, 6); rm = $urandom_range(0, 7);
                s = 1'($urandom_range(0, 1)); ncyc = $urandom_range(1, 14);
            end
            // transition requests that do not belong to IDLE
            nxt = 1; ack = 1;
            step();
            clear_inputs();
            n_cmp++;
            if (obs !== 24'h0) begin
                n_bad++; $display("FAIL idle_ignore p=%0d got=%h exp=%h", p, obs, 24'h0);
            end
            cfg_valid = 1; cfg_cyc = 8'(cm); cfg_ramp = 8'(rm);
            sel_valid = 1; sel = s; go = 1;
            step();
            clear_inputs();
            active = 0;
            for (int k = 0; k < ncyc; k++) begin
                e = exp_obs(1, (active % (cm + 1)) + (s ? SEL_OFFSET : 0), 0, 0);
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("FAIL rnd_cycle p=%0d k=%0d got=%h exp=%h", p, k, obs, e);
                end
                pz = (p != 0) && ($urandom_range(0, 2) == 0);
                pause = pz;
                cfg_valid = 1'($urandom_range(0, 1));
                cfg_cyc = 8'($urandom); cfg_ramp = 8'($urandom);
                sel_valid = 1'($urandom_range(0, 1)); sel = 1'($urandom_range(0, 1));
                go = 1'($urandom_range(0, 1)); ack = 1'($urandom_range(0, 1));
                if (k == ncyc - 1) nxt = 1;
                step();
                clear_inputs();
                if (!pz) active++;
            end
            r = 0; fin = 0;
            while (!fin) begin
                e = exp_obs(2, 0, r, 0);
                n_cmp++;
                if (obs !== e) begin
                    n_bad++; $display("FAIL rnd_ramp p=%0d r=%0d got=%h exp=%h", p, r, obs, e);
                end
                pz = (p != 0) && ($urandom_range(0, 2) == 0);
                pause = pz;
                ack = 1'($urandom_range(0, 1)); go = 1'($urandom_range(0, 1));
                nxt = 1'($urandom_range(0, 1)); cfg_valid = 1'($urandom_range(0, 1));
                cfg_ramp = 8'($urandom); sel_valid = 1; sel = 1'($urandom_range(0, 1));
                step();
                clear_inputs();
                if (!pz) begin
                    if (r == rm) fin = 1;
                    else r++;
                end
            end
            e = exp_obs(4, 0, 0, 1);
            n_cmp++;
            if (obs !== e) begin
                n_bad++; $display("FAIL rnd_done p=%0d got=%h exp=%h", p, obs, e);
            end
            hw = $urandom_range(0, 3);
            for (int i = 0; i < hw; i++) begin
                go = 1'($urandom_range(0, 1)); nxt = 1'($urandom_range(0, 1));
                step();
                clear_inputs();
                e = exp_obs(4, 0, 0, 0);
                n_cmp++;
                if (obs !== e) begin
                    n_bad++; $display("FAIL rnd_hold p=%0d i=%0d got=%h exp=%h", p, i, obs, e);
                end
            end
            ack = 1;
            step();
            clear_inputs();
            n_cmp++;
            if (obs !== 24'h0) begin
                n_bad++; $display("FAIL rnd_idle p=%0d got=%h exp=%h", p, obs, 24'h0);
            end
        end
    endtask

    task automatic test_pause();
        logic [23:0] e;
        int exp_seq [13] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 5, 5, 5, 5};
        bit pz_seq  [13] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 0};
        cfg_valid = 1; cfg_cyc = 8'd3; cfg_ramp = 8'd5; sel_valid = 1; sel = 0; go = 1;
        step();
        clear_inputs();
        nxt = 1; pause = 1;
        step();
        clear_inputs();
        for (int i = 0; i < 13; i++) begin
            e = exp_obs(2, 0, exp_seq[i], 0);
            n_cmp++;
            if (obs !== e) begin
                n_bad++; $display("FAIL pause_ramp i=%0d got=%h exp=%h", i, obs, e);
            end
            pause = pz_seq[i];
            step();
            pause = 0;
        end
        e = exp_obs(4, 0, 0, 1);
        n_cmp++;
        if (obs !== e) begin
            n_bad++; $display("FAIL pause_done got=%h exp=%h", obs, e);
        end
        ack = 1;
        step();
        ack = 0;
    endtask

    task automatic test_hold_timeout();
        logic [23:0] e;
        int ack_at, hold_len;
        pulse_reset();
        for (int run = 0; run < 3; run++) begin
            ack_at = (run == 0) ? -1 : ((run == 1) ? 1 : 3);
            hold_len = (ack_at < 0) ? 4 : ack_at + 1;
            go = 1;
            step();
            go = 0; nxt = 1;
            step();
            nxt = 0;
            repeat (RAMP_DEF + 1) step();
            for (int k = 0; k <= 4; k++) begin
                e = (k < hold_len) ? exp_obs(4, 0, 0, k == 0) : 24'h0;
                n_cmp++;
                if (obs_t !== e) begin
                    n_bad++;
                    $display("FAIL hold_to run=%0d k=%0d got=%h exp=%h", run, k, obs_t, e);
                end
                if (k == ack_at) ack = 1;
                step();
                ack = 0;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] e;
        pulse_reset();
        cfg_valid = 1; cfg_cyc = 8'd2; cfg_ramp = 8'd12; sel_valid = 1; sel = 1; go = 1;
        step();
        clear_inputs();
        e = exp_obs(1, SEL_OFFSET, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++; $display("FAIL rm_cycle got=%h exp=%h", obs, e);
        end
        nxt = 1;
        step();
        nxt = 0;
        for (int j = 0; j <= 7; j++) begin
            e = exp_obs(2, 0, j, 0);
            n_cmp++;
            if (obs !== e) begin
                n_bad++; $display("FAIL rm_ramp j=%0d got=%h exp=%h", j, obs, e);
            end
            if (j < 7) step();
        end
        #2 rst = 0;
        #1;
        n_cmp++;
        if (obs !== 24'h0) begin
            n_bad++; $display("FAIL rm_async got=%h exp=%h", obs, 24'h0);
        end
        @(posedge clk);
        #1;
        rst = 1;
        n_cmp++;
        if (obs !== 24'h0) begin
            n_bad++; $display("FAIL rm_idle got=%h exp=%h", obs, 24'h0);
        end
        go = 1;
        step();
        go = 0;
        for (int k = 0; k < 12; k++) begin
            e = exp_obs(1, k % (CYC_DEF + 1), 0, 0);
            n_cmp++;
            if (obs !== e) begin
                n_bad++; $display("FAIL rm_defcyc k=%0d got=%h exp=%h", k, obs, e);
            end
            if (k == 11) nxt = 1;
            step();
            nxt = 0;
        end
        for (int j = 0; j <= RAMP_DEF; j++) begin
            e = exp_obs(2, 0, j, 0);
            n_cmp++;
            if (obs !== e) begin
                n_bad++; $display("FAIL rm_deframp j=%0d got=%h exp=%h", j, obs, e);
            end
            step();
        end
        e = exp_obs(4, 0, 0, 1);
        n_cmp++;
        if (obs !== e) begin
            n_bad++; $display("FAIL rm_done got=%h exp=%h", obs, e);
        end
        ack = 1;
        step();
        ack = 0;
        n_cmp++;
        if (obs !== 24'h0) begin
            n_bad++; $display("FAIL rm_final got=%h exp=%h", obs, 24'h0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_pass();
        test_random_passes();
        test_pause();
        test_hold_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
